vram_arbiter: RTL
=================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_W, 9, video RAM address width (512 locations).
REQ-002 Parameter DATA_W, 9, video RAM word width (bit 8 = chunky-graphics flag).
REQ-003 vid_clk  in  1  sole clock; all state on its rising edge.
REQ-004 vid_rst  in  1  reset, synchronous and active-high.
REQ-005 vid_req  in  1  video fetch request, single-cycle.
REQ-006 vid_addr  in  ADDR_W  video fetch address.
REQ-007 vid_valid  out  1  video read data valid, one-cycle pulse.
REQ-008 vid_rdata  out  DATA_W  video read data.
REQ-009 cpu_req  in  1  CPU access request, level, held until cpu_ack.
REQ-010 cpu_we  in  1  1=write, 0=read, qualified by cpu_req.
REQ-011 cpu_addr / cpu_wdata  in  ADDR_W / DATA_W  CPU address / write data.
REQ-012 cpu_ack  out  1  CPU transfer complete, one-cycle pulse.
REQ-013 cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ack on reads.
REQ-014 clr_start  in  1  start clear-screen fill, single-cycle.
REQ-015 clr_data  in  DATA_W  fill value, sampled with clr_start.
REQ-016 clr_busy / clr_done  out  1 / 1  fill in progress / one-cycle completion pulse.
REQ-017 ram_addr / ram_we / ram_wdata  out  ADDR_W / 1 / DATA_W  registered RAM port.
REQ-018 ram_rdata  in  DATA_W  RAM read data, one cycle after ram_addr is sampled.

Function
REQ-019 One RAM access granted per cycle, fixed priority: video > CPU > clear.
REQ-020 Request sampled at edge k is driven on ram_* after edge k; ram_we high for exactly that cycle on writes, 0 on reads and idle cycles.
REQ-021 Video read: vid_req at edge k -> vid_valid=1, vid_rdata=mem[vid_addr] for one cycle after edge k+2; fixed 2-cycle latency, never stalled.
REQ-022 Two-stage source-tag pipeline (none/video/CPU) routes ram_rdata; back-to-back reads on consecutive cycles are supported.
REQ-023 CPU FSM states IDLE, RD_WAIT, ACK; cpu_req sampled only in IDLE.
REQ-024 IDLE: cpu_req=1 and no vid_req -> grant; write -> ACK; read -> RD_WAIT. Otherwise stay IDLE (CPU waits, no timeout).
REQ-025 RD_WAIT: wait for granted read's tag to emerge; load cpu_rdata -> ACK. cpu_ack read latency from grant = 2 cycles, write = 1 cycle.
REQ-026 ACK: cpu_ack=1 one cycle, -> IDLE unconditionally; cpu_req still high in ACK is ignored, new request sampled next cycle.
REQ-027 cpu_rdata holds last read value until the next read completes.
REQ-028 Clear FSM states CLR_IDLE, CLR_RUN; clr_start in CLR_IDLE latches clr_data, sets address counter 0, clr_busy=1.
REQ-029 CLR_RUN: on cycles with no video/CPU grant, write fill value to counter address, then increment counter.
REQ-030 Write to address 2^ADDR_W-1 -> clr_done=1 one cycle, clr_busy=0, -> CLR_IDLE; counter wraps to 0.
REQ-031 clr_start while clr_busy=1 is ignored; fill value unchanged.
REQ-032 CPU writes during a clear are performed and may be overwritten later by the fill.
REQ-033 Strict priority: continuous vid_req starves CPU and clear; no fairness mechanism.

Reset
REQ-034 vid_rst=1: both FSMs to idle, tag pipeline cleared, clear counter 0.
REQ-035 All outputs 0 during and after reset: vid_valid, vid_rdata, cpu_ack, cpu_rdata, clr_busy, clr_done, ram_addr, ram_we, ram_wdata.
REQ-036 Reset mid-operation: in-flight reads discarded (no vid_valid/cpu_ack), clear aborted (no clr_done).

Configuration
REQ-037 Macro VRAM_ARBITER_CLEAR_EN defined: clear engine (REQ-028..032) is built.
REQ-038 Macro undefined: no clear logic; clr_busy=0, clr_done=0 always, clr_start/clr_data ignored; other behaviour identical.

Verification
REQ-039 vid_req addr 0x012 (mem=0x141) at edge 10 -> vid_valid=1, vid_rdata=0x141 after edge 12 only.
REQ-040 vid_req and cpu_req (write 0x1FF<-0x055) same edge -> video granted first; ram_we next cycle; cpu_ack 1 cycle later; mem[0x1FF]=0x055.
REQ-041 CPU read addr 0x020 (mem=0x0AB) with vid_req every cycle for 5 cycles -> no CPU grant until vid_req drops; cpu_ack with cpu_rdata=0x0AB 2 cycles after grant.
REQ-042 clr_start, clr_data=0x020, no other traffic -> 512 consecutive writes 0..511, clr_done pulse after 512th, all mem=0x020.
REQ-043 clr_start; vid_rst at fill cycle 100 -> clr_busy=0, no clr_done, no further ram_we; second clr_start restarts at address 0.
REQ-044 Build without VRAM_ARBITER_CLEAR_EN, pulse clr_start -> ram_we never asserted, clr_busy/clr_done stay 0.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port video RAM arbiter.
// Priority video > CPU > clear. Video reads have a fixed 2-cycle latency.
// CPU reads ack 2 cycles after grant and CPU writes ack 1 cycle after grant.
// The clear-screen fill engine is built only when VRAM_ARBITER_CLEAR_EN is defined.
module vram_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 9
) (
  input  logic              vid_clk,
  input  logic              vid_rst,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_data,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_CPU} tag_t;
  typedef enum logic [1:0] {IDLE, RD_WAIT, ACK} cpu_st_t;

  cpu_st_t            cpu_st, cpu_nxt;
  tag_t               tag_pipe [2];   // [0] aligned with ram_addr, [1] with ram_rdata
  logic               vid_gnt, cpu_gnt, clr_gnt;
  logic [ADDR_W-1:0]  clr_cnt;
  logic [DATA_W-1:0]  clr_val;

  // Video always wins; the CPU is also held off during its own ack cycle so a
  // request still high while cpu_ack is asserted is not taken twice.
  assign vid_gnt = vid_req;
  assign cpu_gnt = (cpu_st == IDLE) && !cpu_ack && cpu_req && !vid_req;

  // CPU FSM state register
  always_ff @(posedge vid_clk) begin
    if (vid_rst) cpu_st <= IDLE;
    else         cpu_st <= cpu_nxt;
  end

  // CPU FSM next state: reads pass through RD_WAIT while their data is in flight
  always_comb begin
    cpu_nxt = cpu_st;
    case (cpu_st)
      IDLE:    if (cpu_gnt) cpu_nxt = cpu_we ? ACK : RD_WAIT;
      RD_WAIT: if (tag_pipe[0] == TAG_CPU) cpu_nxt = ACK;
      ACK:     cpu_nxt = IDLE;
      default: cpu_nxt = IDLE;
    endcase
  end

  // CPU ack pulse and read data capture as the CPU tag leaves the pipeline
  always_ff @(posedge vid_clk) begin
    if (vid_rst) begin
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      cpu_ack <= (cpu_st == ACK);
      if (tag_pipe[1] == TAG_CPU) cpu_rdata <= ram_rdata;
    end
  end

`ifdef VRAM_ARBITER_CLEAR_EN
  typedef enum logic {CLR_IDLE, CLR_RUN} clr_st_t;
  clr_st_t clr_st, clr_nxt;
  logic    clr_last;

  // Fill only uses cycles neither video nor CPU claimed
  assign clr_gnt  = (clr_st == CLR_RUN) && !vid_req && !cpu_gnt;
  assign clr_last = clr_gnt && (clr_cnt == '1);
  assign clr_busy = (clr_st == CLR_RUN);

  // Clear FSM state register
  always_ff @(posedge vid_clk) begin
    if (vid_rst) clr_st <= CLR_IDLE;
    else         clr_st <= clr_nxt;
  end

  // Clear FSM next state; clr_start while running is ignored
  always_comb begin
    clr_nxt = clr_st;
    case (clr_st)
      CLR_IDLE: if (clr_start) clr_nxt = CLR_RUN;
      CLR_RUN:  if (clr_last)  clr_nxt = CLR_IDLE;
      default:  clr_nxt = CLR_IDLE;
    endcase
  end

  // Fill value latch, address counter (wraps to 0 after the last word), done pulse
  always_ff @(posedge vid_clk) begin
    if (vid_rst) begin
      clr_cnt  <= '0;
      clr_val  <= '0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= clr_last;
      if (clr_st == CLR_IDLE && clr_start) begin
        clr_cnt <= '0;
        clr_val <= clr_data;
      end else if (clr_gnt) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_clr;
  assign unused_clr = ^{clr_start, clr_data};
  assign clr_gnt    = 1'b0;
  assign clr_busy   = 1'b0;
  assign clr_done   = 1'b0;
  assign clr_cnt    = '0;
  assign clr_val    = '0;
`endif

  // Registered RAM port: one granted access per cycle, write strobe for one cycle
  always_ff @(posedge vid_clk) begin
    if (vid_rst) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
    end else if (vid_gnt) begin
      ram_addr  <= vid_addr;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
    end else if (cpu_gnt) begin
      ram_addr  <= cpu_addr;
      ram_we    <= cpu_we;
      ram_wdata <= cpu_we ? cpu_wdata : '0;
    end else if (clr_gnt) begin
      ram_addr  <= clr_cnt;
      ram_we    <= 1'b1;
      ram_wdata <= clr_val;
    end else begin
      ram_we    <= 1'b0;
    end
  end

  // Source-tag pipeline so returning read data reaches the right requester
  always_ff @(posedge vid_clk) begin
    if (vid_rst) begin
      tag_pipe[0] <= TAG_NONE;
      tag_pipe[1] <= TAG_NONE;
    end else begin
      tag_pipe[0] <= vid_gnt ? TAG_VID : ((cpu_gnt && !cpu_we) ? TAG_CPU : TAG_NONE);
      tag_pipe[1] <= tag_pipe[0];
    end
  end

  // Video return path: one-cycle valid, data held between fetches
  always_ff @(posedge vid_clk) begin
    if (vid_rst) begin
      vid_valid <= 1'b0;
      vid_rdata <= '0;
    end else begin
      vid_valid <= (tag_pipe[1] == TAG_VID);
      if (tag_pipe[1] == TAG_VID) vid_rdata <= ram_rdata;
    end
  end

endmodule
